// File: rtl/pcm_voice_mixer_pkg.sv
// Shared types, defaults and the output saturation helper for the PCM voice mixer.
// Saturation is fixed at 16-bit output, so PCM_W must stay at its default of 16.
package pcm_voice_mixer_pkg;

  localparam int PCM_W_DEF      = 16;
  localparam int VOL_W_DEF      = 6;
  localparam int PAN_W_DEF      = 4;
  localparam int MAX_VOICES     = 16;
  localparam int ACC_MAX_W      = PCM_W_DEF + VOL_W_DEF + 6 + $clog2(MAX_VOICES);

  localparam logic signed [ACC_MAX_W-1:0] SAT_HI = (2 ** (PCM_W_DEF - 1)) - 1;
  localparam logic signed [ACC_MAX_W-1:0] SAT_LO = -(2 ** (PCM_W_DEF - 1));

  typedef logic signed [PCM_W_DEF-1:0] pcm_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT,
    OUT
  } mix_state_t;

  typedef struct packed {
    pcm_t value;
    logic clipped;
  } sat_t;

  // Scale the accumulator back to sample range and clamp to the 16-bit signed range.
  function automatic sat_t sat16(input logic signed [ACC_MAX_W-1:0] acc, input int shift);
    logic signed [ACC_MAX_W-1:0] v;
    sat_t r;
    v = acc >>> shift;
    if (v > SAT_HI) begin
      r.value   = SAT_HI[PCM_W_DEF-1:0];
      r.clipped = 1'b1;
    end else if (v < SAT_LO) begin
      r.value   = SAT_LO[PCM_W_DEF-1:0];
      r.clipped = 1'b1;
    end else begin
      r.value   = v[PCM_W_DEF-1:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcm_voice_mixer_if.sv
// Mixed stereo sample bus from the voice mixer to the PCM serializer.
interface pcm_voice_mixer_if #(
    parameter int PCM_W = 16
);

    logic signed [PCM_W-1:0] pcm_data_left;
    logic signed [PCM_W-1:0] pcm_data_right;
    logic                    pcm_data_valid;

    modport master (
        output pcm_data_left,
        output pcm_data_right,
        output pcm_data_valid
    );

    modport slave (
        input pcm_data_left,
        input pcm_data_right,
        input pcm_data_valid
    );

endinterface

// File: rtl/pcm_voice_mixer_mac.sv
// Combinational sample * volume * pan-weight product for one voice; one instance per channel.
module pcm_voice_mixer_mac #(
    parameter int PCM_W  = 16,
    parameter int VOL_W  = 6,
    parameter int PAN_W  = 4,
    parameter int PROD_W = PCM_W + VOL_W + 6
) (
    input  logic signed [PCM_W-1:0]  sample,
    input  logic        [VOL_W-1:0]  volume,
    input  logic        [PAN_W:0]    weight,
    input  logic                     enable,
    output logic signed [PROD_W-1:0] product
);

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] volume_ext;
    logic signed [PROD_W-1:0] weight_ext;

    // Operands are widened first so the product is formed at full width; the true
    // magnitude never exceeds 2^(PCM_W+VOL_W+PAN_W-1), well inside PROD_W.
    always_comb begin
        sample_ext = PROD_W'(sample);
        volume_ext = PROD_W'({1'b0, volume});
        weight_ext = PROD_W'({1'b0, weight});
        product    = enable ? sample_ext * volume_ext * weight_ext : '0;
    end

endmodule

// File: rtl/pcm_voice_mixer.sv
// Time-multiplexed N-voice stereo mixer: snapshot on sample_tick, one voice per clk, saturate, present.
// Stereo pan is built only when PCM_VOICE_MIXER_PAN_EN is defined; otherwise the mix is mono (L == R).
module pcm_voice_mixer
    import pcm_voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PCM_W      = PCM_W_DEF,
    parameter int VOL_W      = VOL_W_DEF,
    parameter int PAN_W      = PAN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_active_high,
    input  logic                    sample_tick,
    input  logic signed [PCM_W-1:0] voice_sample [NUM_VOICES],
    input  logic        [VOL_W-1:0] voice_volume [NUM_VOICES],
    input  logic        [PAN_W-1:0] voice_pan    [NUM_VOICES],
    input  logic [NUM_VOICES-1:0]   voice_enable,
    pcm_voice_mixer_if.master       pcm,
    output logic                    busy,
    output logic                    clip,
    output logic                    overrun
);

    localparam int PROD_W = PCM_W + VOL_W + 6;
    localparam int ACC_W  = PCM_W + VOL_W + 6 + $clog2(NUM_VOICES);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SHIFT  = VOL_W + PAN_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [PAN_W:0]   W_UNITY  = {1'b1, {PAN_W{1'b0}}};

    mix_state_t state, state_next;

    logic signed [PCM_W-1:0] snap_sample [NUM_VOICES];
    logic        [VOL_W-1:0] snap_volume [NUM_VOICES];
    logic [NUM_VOICES-1:0]   snap_en;

    logic        [IDX_W-1:0]  idx;
    logic signed [ACC_W-1:0]  acc_l, acc_r;
    logic signed [PCM_W-1:0]  sat_l, sat_r;
    logic signed [PCM_W-1:0]  cur_sample;
    logic        [VOL_W-1:0]  cur_volume;
    logic                     cur_en;
    logic        [PAN_W:0]    w_l, w_r;
    logic signed [PROD_W-1:0] prod_l, prod_r;
    sat_t                     res_l, res_r;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_active_high) state <= IDLE;
        else                 state <= state_next;
    end

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_next = SAT;
            SAT:     state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Current voice and pan weights
    // ------------------------------------------------------------------
`ifdef PCM_VOICE_MIXER_PAN_EN
    logic [PAN_W-1:0] snap_pan [NUM_VOICES];

    always_comb begin
        w_l = W_UNITY - {1'b0, snap_pan[idx]};
        w_r = {1'b0, snap_pan[idx]};
    end
`else
    logic unused_pan;

    // Mono build: pan has no effect and is only folded here to mark it as consumed.
    always_comb begin
        unused_pan = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) unused_pan ^= ^voice_pan[i];
        w_l = W_UNITY;
        w_r = W_UNITY;
    end
`endif

    always_comb begin
        cur_sample = snap_sample[idx];
        cur_volume = snap_volume[idx];
        cur_en     = snap_en[idx];
    end

    pcm_voice_mixer_mac #(
        .PCM_W  (PCM_W),
        .VOL_W  (VOL_W),
        .PAN_W  (PAN_W),
        .PROD_W (PROD_W)
    ) u_mac_l (
        .sample  (cur_sample),
        .volume  (cur_volume),
        .weight  (w_l),
        .enable  (cur_en),
        .product (prod_l)
    );

    pcm_voice_mixer_mac #(
        .PCM_W  (PCM_W),
        .VOL_W  (VOL_W),
        .PAN_W  (PAN_W),
        .PROD_W (PROD_W)
    ) u_mac_r (
        .sample  (cur_sample),
        .volume  (cur_volume),
        .weight  (w_r),
        .enable  (cur_en),
        .product (prod_r)
    );

    always_comb begin
        res_l = sat16(ACC_MAX_W'(acc_l), SHIFT);
        res_r = sat16(ACC_MAX_W'(acc_r), SHIFT);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same clock edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_active_high) begin
            idx                <= '0;
            acc_l              <= '0;
            acc_r              <= '0;
            sat_l              <= '0;
            sat_r              <= '0;
            snap_en            <= '0;
            pcm.pcm_data_left  <= '0;
            pcm.pcm_data_right <= '0;
            pcm.pcm_data_valid <= 1'b0;
            clip               <= 1'b0;
            overrun            <= 1'b0;
            // NOTE: the snapshot is a handful of flops, not a RAM, so clearing it
            // on reset is cheap and keeps a post-reset mix free of stale voices.
            for (int i = 0; i < NUM_VOICES; i++) begin
                snap_sample[i] <= '0;
                snap_volume[i] <= '0;
`ifdef PCM_VOICE_MIXER_PAN_EN
                snap_pan[i]    <= '0;
`endif
            end
        end else begin
            pcm.pcm_data_valid <= (state == OUT);
            if (sample_tick && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            snap_sample[i] <= voice_sample[i];
                            snap_volume[i] <= voice_volume[i];
`ifdef PCM_VOICE_MIXER_PAN_EN
                            snap_pan[i]    <= voice_pan[i];
`endif
                        end
                        snap_en <= voice_enable;
                        idx     <= '0;
                        acc_l   <= '0;
                        acc_r   <= '0;
                    end
                end
                ACCUM: begin
                    acc_l <= acc_l + ACC_W'(prod_l);
                    acc_r <= acc_r + ACC_W'(prod_r);
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                SAT: begin
                    sat_l <= res_l.value;
                    sat_r <= res_r.value;
                    if (res_l.clipped || res_r.clipped) clip <= 1'b1;
                end
                OUT: begin
                    pcm.pcm_data_left  <= sat_l;
                    pcm.pcm_data_right <= sat_r;
                end
                default: ;
            endcase
        end
    end

endmodule
